tcam_pri: RTL and testbench

TCAM_PRI -- requirements
Module: tcam_pri

---
 rtl/tcam_pri_if.sv | 31 +++
 rtl/tcam_pri.sv | 134 +++++++++++++
 tb/tb_tcam_pri.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tcam_pri_if.sv
// Bus bundle for the priority TCAM: write/invalidate port, search request
// and the registered search result.
interface tcam_pri_if #(
  parameter int WIDTH = 16,
  parameter int AW    = 4
);
  logic             we;
  logic             inv;
  logic [AW-1:0]    waddr;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] wmask;
  logic             search;
  logic [WIDTH-1:0] skey;
  logic             rvalid;
  logic             found;
  logic [AW-1:0]    saddr;
  logic [WIDTH-1:0] sdata;
  logic [WIDTH-1:0] smask;
  logic [AW:0]      mcount;
  logic             multi;

  modport master (
    output we, inv, waddr, wdata, wmask, search, skey,
    input  rvalid, found, saddr, sdata, smask, mcount, multi
  );

  modport slave (
    input  we, inv, waddr, wdata, wmask, search, skey,
    output rvalid, found, saddr, sdata, smask, mcount, multi
  );
endinterface

// File: rtl/tcam_pri.sv
// Ternary CAM with per-bit care mask and a two-stage search pipeline:
// match vector + entry snapshot, then priority encode / popcount / readout.
module tcam_pri #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic       clk,
  input  logic       rstN,
  tcam_pri_if.slave  bus
);

  logic [WIDTH-1:0] r_mem   [DEPTH];
  logic [WIDTH-1:0] r_mask  [DEPTH];
  logic [DEPTH-1:0] r_valid;

  logic             r_s1_valid;
  logic [DEPTH-1:0] r_s1_match;
  logic [WIDTH-1:0] r_s1_mem  [DEPTH];
  logic [WIDTH-1:0] r_s1_mask [DEPTH];

  logic [DEPTH-1:0] w_match;
  logic             w_found;
  logic [AW-1:0]    w_saddr;
  logic [WIDTH-1:0] w_sdata;
  logic [WIDTH-1:0] w_smask;
  logic [AW:0]      w_mcount;

  logic             r_rvalid;
  logic             r_found;
  logic [AW-1:0]    r_saddr;
  logic [WIDTH-1:0] r_sdata;
  logic [WIDTH-1:0] r_smask;
  logic [AW:0]      r_mcount;
  logic             r_multi;

  // Entry storage: contents are left unreset since invalid entries never match.
  always_ff @(posedge clk) begin
    if (rstN && bus.we) begin
      r_mem[bus.waddr]  <= bus.wdata;
      r_mask[bus.waddr] <= bus.wmask;
    end
  end

  // Valid bits; a write wins over a simultaneous invalidate.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      r_valid <= {DEPTH{1'b0}};
    end else if (bus.we) begin
      r_valid[bus.waddr] <= 1'b1;
    end else if (bus.inv) begin
      r_valid[bus.waddr] <= 1'b0;
    end
  end

  // Per-entry ternary compare against the pre-write table contents.
  always_comb begin
    w_match = {DEPTH{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      w_match[i] = r_valid[i] && (((r_mem[i] ^ bus.skey) & r_mask[i]) == {WIDTH{1'b0}});
    end
  end

  // Stage 1 control: match vector and in-flight qualifier.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      r_s1_valid <= 1'b0;
      r_s1_match <= {DEPTH{1'b0}};
    end else begin
      r_s1_valid <= bus.search;
      if (bus.search) begin
        r_s1_match <= w_match;
      end
    end
  end

  // Stage 1 snapshot so later writes cannot disturb an in-flight readout.
  always_ff @(posedge clk) begin
    if (rstN && bus.search) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_s1_mem[i]  <= r_mem[i];
        r_s1_mask[i] <= r_mask[i];
      end
    end
  end

  // Stage 2 combinational: descending scan leaves the lowest matching index.
  always_comb begin
    w_found  = 1'b0;
    w_saddr  = {AW{1'b0}};
    w_sdata  = {WIDTH{1'b0}};
    w_smask  = {WIDTH{1'b0}};
    w_mcount = {(AW+1){1'b0}};
    for (int i = DEPTH - 1; i >= 0; i--) begin
      w_found  = r_s1_match[i] ? 1'b1         : w_found;
      w_saddr  = r_s1_match[i] ? AW'(i)       : w_saddr;
      w_sdata  = r_s1_match[i] ? r_s1_mem[i]  : w_sdata;
      w_smask  = r_s1_match[i] ? r_s1_mask[i] : w_smask;
      w_mcount = w_mcount + {{AW{1'b0}}, r_s1_match[i]};
    end
  end

  // Stage 2 result registers; results hold between rvalid pulses.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      r_rvalid <= 1'b0;
      r_found  <= 1'b0;
      r_saddr  <= {AW{1'b0}};
      r_sdata  <= {WIDTH{1'b0}};
      r_smask  <= {WIDTH{1'b0}};
      r_mcount <= {(AW+1){1'b0}};
      r_multi  <= 1'b0;
    end else begin
      r_rvalid <= r_s1_valid;
      if (r_s1_valid) begin
        r_found  <= w_found;
        r_saddr  <= w_saddr;
        r_sdata  <= w_sdata;
        r_smask  <= w_smask;
        r_mcount <= w_mcount;
        r_multi  <= (w_mcount > {{AW{1'b0}}, 1'b1});
      end
    end
  end

  assign bus.rvalid = r_rvalid;
  assign bus.found  = r_found;
  assign bus.saddr  = r_saddr;
  assign bus.sdata  = r_sdata;
  assign bus.smask  = r_smask;
  assign bus.mcount = r_mcount;
  assign bus.multi  = r_multi;

endmodule

// File: tb/tb_tcam_pri.sv
// Self-checking bench for tcam_pri: directed scenarios plus randomized
// traffic checked against a table-level reference model.
module tb_tcam_pri;
  localparam int W  = 16;
  localparam int D  = 16;
  localparam int AW = 4;

  typedef struct packed {
    logic          found;
    logic [AW-1:0] saddr;
    logic [W-1:0]  sdata;
    logic [W-1:0]  smask;
    logic [AW:0]   mcount;
    logic          multi;
  } res_t;

  logic clk = 1'b0;
  logic rstN;
  always #5 clk = ~clk;

  tcam_pri_if #(.WIDTH(W), .AW(AW)) bus ();
  tcam_pri #(.WIDTH(W), .DEPTH(D), .AW(AW)) dut (.clk(clk), .rstN(rstN), .bus(bus));

  logic [W-1:0] m_mem  [D];
  logic [W-1:0] m_mask [D];
  bit           m_valid[D];
  res_t         exp_q[$];
  int           due_q[$];
  res_t         exp_res;
  res_t         last_res;
  logic         exp_rvalid;
  int           cyc      = 0;
  int           checks   = 0;
  int           failures = 0;

  function automatic res_t model_search(input logic [W-1:0] key);
    res_t r;
    int   cnt;
    r   = '0;
    cnt = 0;
    for (int i = 0; i < D; i++) begin
      if (m_valid[i] && (((m_mem[i] ^ key) & m_mask[i]) == 16'h0000)) begin
        cnt++;
        if (!r.found) begin
          r.found = 1'b1;
          r.saddr = AW'(i);
          r.sdata = m_mem[i];
          r.smask = m_mask[i];
        end
      end
    end
    r.mcount = (AW+1)'(cnt);
    r.multi  = (cnt > 1);
    return r;
  endfunction

  // One clock: drive inputs, update the model, advance, compute expectations.
  task automatic tick(input logic rn, input logic we, input logic inv,
                      input logic [AW-1:0] a, input logic [W-1:0] d, input logic [W-1:0] m,
                      input logic s, input logic [W-1:0] k);
    rstN       = rn;
    bus.we     = we;
    bus.inv    = inv;
    bus.waddr  = a;
    bus.wdata  = d;
    bus.wmask  = m;
    bus.search = s;
    bus.skey   = k;
    if (!rn) begin
      exp_q.delete();
      due_q.delete();
      for (int i = 0; i < D; i++) m_valid[i] = 1'b0;
    end else begin
      if (s) begin
        exp_q.push_back(model_search(k));
        due_q.push_back(cyc + 2);
      end
      if (we) begin
        m_mem[a]   = d;
        m_mask[a]  = m;
        m_valid[a] = 1'b1;
      end else if (inv) begin
        m_valid[a] = 1'b0;
      end
    end
    @(posedge clk);
    cyc++;
    #1;
    if (!rn) begin
      exp_rvalid = 1'b0;
      exp_res    = '0;
      last_res   = '0;
    end else if (due_q.size() > 0 && due_q[0] == cyc) begin
      exp_rvalid = 1'b1;
      exp_res    = exp_q.pop_front();
      void'(due_q.pop_front());
      last_res   = exp_res;
    end else begin
      exp_rvalid = 1'b0;
      exp_res    = last_res;
    end
  endtask

  task automatic idle();
    tick(1'b1, 1'b0, 1'b0, 4'd0, 16'h0000, 16'h0000, 1'b0, 16'h0000);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [W-1:0] d, input logic [W-1:0] m);
    tick(1'b1, 1'b1, 1'b0, a, d, m, 1'b0, 16'h0000);
  endtask

  task automatic srch(input logic [W-1:0] k);
    tick(1'b1, 1'b0, 1'b0, 4'd0, 16'h0000, 16'h0000, 1'b1, k);
  endtask

  task automatic test_reset();
    tick(1'b0, 1'b1, 1'b0, 4'd1, 16'h1111, 16'hFFFF, 1'b1, 16'h1111);
    tick(1'b0, 1'b0, 1'b0, 4'd0, 16'h0000, 16'h0000, 1'b0, 16'h0000);
    checks++;
    if ({bus.rvalid, bus.found, bus.saddr, bus.sdata, bus.smask, bus.mcount, bus.multi} !== 59'd0) begin
      failures++;
      $display("FAIL reset_outputs got rvalid=%b found=%b saddr=%0d sdata=%h smask=%h mcount=%0d multi=%b required all zero",
               bus.rvalid, bus.found, bus.saddr, bus.sdata, bus.smask, bus.mcount, bus.multi);
    end
    idle();
    idle();
    checks++;
    if (bus.rvalid !== 1'b0) begin
      failures++;
      $display("FAIL reset_no_pulse got rvalid=%b required 0", bus.rvalid);
    end
  endtask

  task automatic test_empty();
    srch(16'h1234);
    checks++;
    if (bus.rvalid !== 1'b0) begin
      failures++;
      $display("FAIL empty_latency got rvalid=%b one cycle after search required 0", bus.rvalid);
    end
    idle();
    checks++;
    if (bus.rvalid !== 1'b1 || bus.found !== 1'b0 || bus.mcount !== 5'd0) begin
      failures++;
      $display("FAIL empty_search got rvalid=%b found=%b mcount=%0d required 1/0/0",
               bus.rvalid, bus.found, bus.mcount);
    end
  endtask

  task automatic test_priority();
    wr(4'd5, 16'h00A0, 16'hFFF0);
    wr(4'd9, 16'h00A3, 16'hFFFF);
    srch(16'h00A3);
    idle();
    checks++;
    if (bus.rvalid !== 1'b1 || bus.found !== 1'b1 || bus.saddr !== 4'd5 || bus.sdata !== 16'h00A0 ||
        bus.smask !== 16'hFFF0 || bus.mcount !== 5'd2 || bus.multi !== 1'b1) begin
      failures++;
      $display("FAIL priority got rvalid=%b found=%b saddr=%0d sdata=%h smask=%h mcount=%0d multi=%b required 1/1/5/00a0/fff0/2/1",
               bus.rvalid, bus.found, bus.saddr, bus.sdata, bus.smask, bus.mcount, bus.multi);
    end
    idle();
    checks++;
    if (bus.rvalid !== 1'b0 || bus.saddr !== 4'd5 || bus.mcount !== 5'd2) begin
      failures++;
      $display("FAIL hold got rvalid=%b saddr=%0d mcount=%0d required 0/5/2", bus.rvalid, bus.saddr, bus.mcount);
    end
  endtask

  task automatic test_invalidate();
    tick(1'b1, 1'b0, 1'b1, 4'd5, 16'h0000, 16'h0000, 1'b0, 16'h0000);
    srch(16'h00A3);
    idle();
    checks++;
    if (bus.rvalid !== 1'b1 || bus.found !== 1'b1 || bus.saddr !== 4'd9 || bus.mcount !== 5'd1 || bus.multi !== 1'b0) begin
      failures++;
      $display("FAIL invalidate got rvalid=%b found=%b saddr=%0d mcount=%0d multi=%b required 1/1/9/1/0",
               bus.rvalid, bus.found, bus.saddr, bus.mcount, bus.multi);
    end
    srch(16'h00A7);
    idle();
    checks++;
    if (bus.rvalid !== 1'b1 || bus.found !== 1'b0 || bus.saddr !== 4'd0 || bus.sdata !== 16'h0000 ||
        bus.smask !== 16'h0000 || bus.mcount !== 5'd0 || bus.multi !== 1'b0) begin
      failures++;
      $display("FAIL no_match got rvalid=%b found=%b saddr=%0d sdata=%h smask=%h mcount=%0d multi=%b required 1/0/0/0/0/0/0",
               bus.rvalid, bus.found, bus.saddr, bus.sdata, bus.smask, bus.mcount, bus.multi);
    end
  endtask

  task automatic test_same_cycle();
    tick(1'b1, 1'b1, 1'b0, 4'd0, 16'h5555, 16'h0000, 1'b1, 16'hBEEF);
    srch(16'hBEEF);
    checks++;
    if (bus.rvalid !== 1'b1 || bus.found !== 1'b0) begin
      failures++;
      $display("FAIL same_cycle_old got rvalid=%b found=%b required 1/0", bus.rvalid, bus.found);
    end
    idle();
    checks++;
    if (bus.rvalid !== 1'b1 || bus.found !== 1'b1 || bus.saddr !== 4'd0 || bus.mcount !== 5'd1) begin
      failures++;
      $display("FAIL same_cycle_new got rvalid=%b found=%b saddr=%0d mcount=%0d required 1/1/0/1",
               bus.rvalid, bus.found, bus.saddr, bus.mcount);
    end
  endtask

  task automatic test_we_inv();
    tick(1'b1, 1'b1, 1'b1, 4'd3, 16'h0777, 16'hFFFF, 1'b0, 16'h0000);
    tick(1'b1, 1'b0, 1'b1, 4'd7, 16'h0000, 16'h0000, 1'b0, 16'h0000);
    srch(16'h0777);
    idle();
    checks++;
    if (bus.rvalid !== 1'b1 || bus.saddr !== 4'd0 || bus.mcount !== 5'd2 || bus.multi !== 1'b1) begin
      failures++;
      $display("FAIL we_over_inv got rvalid=%b saddr=%0d mcount=%0d multi=%b required 1/0/2/1",
               bus.rvalid, bus.saddr, bus.mcount, bus.multi);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] keys[4];
    int pulses;
    int first;
    keys[0] = 16'h00A3; keys[1] = 16'h00A4; keys[2] = 16'h0777; keys[3] = 16'h1111;
    pulses = 0;
    first  = -1;
    tick(1'b1, 1'b0, 1'b1, 4'd0, 16'h0000, 16'h0000, 1'b0, 16'h0000);
    for (int i = 0; i < 6; i++) begin
      if (i < 4) srch(keys[i]);
      else       idle();
      checks++;
      if ({bus.rvalid, bus.found, bus.saddr, bus.sdata, bus.smask, bus.mcount, bus.multi} !== {exp_rvalid, exp_res}) begin
        failures++;
        $display("FAIL b2b_step%0d got %h required %h", i,
                 {bus.rvalid, bus.found, bus.saddr, bus.sdata, bus.smask, bus.mcount, bus.multi}, {exp_rvalid, exp_res});
      end
      if (bus.rvalid === 1'b1) begin
        pulses++;
        if (first < 0) first = i;
      end
    end
    checks++;
    if (pulses != 4 || first != 1) begin
      failures++;
      $display("FAIL b2b_pulses got %0d pulses starting step %0d required 4 starting step 1", pulses, first);
    end
    srch(16'h00A3);
    srch(16'h0777);
    tick(1'b0, 1'b0, 1'b0, 4'd0, 16'h0000, 16'h0000, 1'b0, 16'h0000);
    checks++;
    if ({bus.rvalid, bus.found, bus.saddr, bus.sdata, bus.smask, bus.mcount, bus.multi} !== 59'd0) begin
      failures++;
      $display("FAIL flush_reset got rvalid=%b found=%b saddr=%0d mcount=%0d required all zero",
               bus.rvalid, bus.found, bus.saddr, bus.mcount);
    end
    idle();
    checks++;
    if (bus.rvalid !== 1'b0 || bus.found !== 1'b0 || bus.mcount !== 5'd0) begin
      failures++;
      $display("FAIL flush_no_pulse got rvalid=%b found=%b mcount=%0d required 0/0/0", bus.rvalid, bus.found, bus.mcount);
    end
  endtask

  task automatic test_fill_all();
    logic [W-1:0] k;
    for (int i = 0; i < D; i++) wr(AW'(i), W'($urandom), 16'h0000);
    k = W'($urandom);
    srch(k);
    idle();
    checks++;
    if (bus.rvalid !== 1'b1 || bus.found !== 1'b1 || bus.mcount !== 5'b10000 || bus.saddr !== 4'd0 || bus.multi !== 1'b1) begin
      failures++;
      $display("FAIL fill_all key=%h got rvalid=%b found=%b mcount=%0d saddr=%0d multi=%b required 1/1/16/0/1",
               k, bus.rvalid, bus.found, bus.mcount, bus.saddr, bus.multi);
    end
  endtask

  task automatic test_random();
    tick(1'b0, 1'b0, 1'b0, 4'd0, 16'h0000, 16'h0000, 1'b0, 16'h0000);
    for (int n = 0; n < 400; n++) begin
      tick(1'b1, ($urandom_range(0, 2) == 0), ($urandom_range(0, 4) == 0), AW'($urandom_range(0, D - 1)),
           W'($urandom_range(0, 15)), (($urandom_range(0, 7) == 0) ? 16'h0000 : W'($urandom & $urandom & $urandom)),
           ($urandom_range(0, 3) != 0), W'($urandom_range(0, 15)));
      checks++;
      if ({bus.rvalid, bus.found, bus.saddr, bus.sdata, bus.smask, bus.mcount, bus.multi} !== {exp_rvalid, exp_res}) begin
        failures++;
        $display("FAIL random_cycle%0d got %h required %h", n,
                 {bus.rvalid, bus.found, bus.saddr, bus.sdata, bus.smask, bus.mcount, bus.multi}, {exp_rvalid, exp_res});
      end
    end
  endtask

  initial begin
    rstN       = 1'b0;
    bus.we     = 1'b0;
    bus.inv    = 1'b0;
    bus.waddr  = 4'd0;
    bus.wdata  = 16'h0000;
    bus.wmask  = 16'h0000;
    bus.search = 1'b0;
    bus.skey   = 16'h0000;
    exp_res    = '0;
    last_res   = '0;
    exp_rvalid = 1'b0;
    test_reset();
    test_empty();
    test_priority();
    test_invalidate();
    test_same_cycle();
    test_we_inv();
    test_back_to_back();
    test_fill_all();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
